// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multicycle MULT/DIV engine, one bit per cycle, HI/LO write strobe on done.
// Define MULDIV_UNSIGNED_EN to add MULTU/DIVU on op[1]; otherwise op[1] is ignored.
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             hi_lo_w,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;
   state_t             state;
   logic [WIDTH-1:0]   a_r, b_r;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   cnt;
   logic               is_div, neg_lo, neg_hi, sa, sb;
   logic [WIDTH:0]     add_sum, trial;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   q_fix, r_fix;

`ifdef MULDIV_UNSIGNED_EN
   logic uns;
   assign sa = a_r[WIDTH-1] & ~uns;
   assign sb = b_r[WIDTH-1] & ~uns;
`else
   logic unused_op1;
   assign unused_op1 = op[1];
   assign sa = a_r[WIDTH-1];
   assign sb = b_r[WIDTH-1];
`endif

   // acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV
   assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);
   assign trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_r};
   assign prod_fix = neg_lo ? -acc : acc;
   assign q_fix    = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign r_fix    = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state    <= IDLE;
         a_r      <= '0;
         b_r      <= '0;
         acc      <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
`ifdef MULDIV_UNSIGNED_EN
         uns      <= 1'b0;
`endif
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi_lo_w  <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_r    <= a_in;
               b_r    <= b_in;
               is_div <= op[0];
`ifdef MULDIV_UNSIGNED_EN
               uns    <= op[1];
`endif
               busy   <= 1'b1;
               state  <= LOAD;
            end
            LOAD: begin
               neg_lo <= sa ^ sb;
               neg_hi <= sa;
               acc    <= {{WIDTH{1'b0}}, sa ? -a_r : a_r};
               b_r    <= sb ? -b_r : b_r;
               cnt    <= '0;
               state  <= (is_div && b_r == '0) ? DONE : RUN;
            end
            RUN: begin
               acc <= !is_div ? {add_sum, acc[WIDTH-1:1]} :
                      trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
                      {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
            end
            FIX: begin
               hi_out  <= is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
               lo_out  <= is_div ? q_fix : prod_fix[WIDTH-1:0];
               done    <= 1'b1;
               hi_lo_w <= 1'b1;
               busy    <= 1'b0;
               state   <= DONE;
            end
            DONE: if (done) begin
               done     <= 1'b0;
               hi_lo_w  <= 1'b0;
               div_zero <= 1'b0;
               state    <= IDLE;
            end else begin
               // divide-by-zero arrives here straight from LOAD; pulse one cycle later with no write
               done     <= 1'b1;
               div_zero <= 1'b1;
               busy     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vector table, hand sequences for abort/ignored start, and
// randomized ops checked against a plain-arithmetic reference model.
module tb_muldiv_sequencer;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset_in, start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a_in, b_in;
   logic             busy, done, div_zero, hi_lo_w;
   logic [WIDTH-1:0] hi_out, lo_out;

   int checks = 0;
   int errors = 0;
   logic [31:0] mhi = '0, mlo = '0;

   muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clk(clk), .reset_in(reset_in), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
      .busy(busy), .done(done), .div_zero(div_zero), .hi_lo_w(hi_lo_w),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      logic        dz;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ph, input logic [31:0] pl,
                                 output logic [31:0] eh, output logic [31:0] el, output logic ez);
      longint x, y, p, q, r;
      logic uns;
`ifdef MULDIV_UNSIGNED_EN
      uns = o[1];
`else
      uns = 1'b0;
`endif
      x  = uns ? longint'({32'b0, a}) : longint'($signed(a));
      y  = uns ? longint'({32'b0, b}) : longint'($signed(b));
      ez = o[0] && (b == 0);
      eh = ph;
      el = pl;
      if (o[0] && !ez) begin
         q  = x / y;
         r  = x % y;
         eh = r[31:0];
         el = q[31:0];
      end else if (!o[0]) begin
         p  = x * y;
         eh = p[63:32];
         el = p[31:0];
      end
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'($urandom_range(0, 20));
         2: return -32'($urandom_range(1, 20));
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after the done pulse,
   // which lets the next call start back-to-back.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez);
      int cyc;
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(negedge clk);
      start = 1'b0; a_in = $urandom; b_in = $urandom;
      chk("busy_after_start", 64'(busy), 64'd1);
      cyc = 0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      chk("latency", 64'(cyc), ez ? 64'd2 : 64'(WIDTH + 2));
      chk("hi_out", 64'(hi_out), 64'(eh));
      chk("lo_out", 64'(lo_out), 64'(el));
      chk("div_zero", 64'(div_zero), 64'(ez));
      chk("hi_lo_w", 64'(hi_lo_w), 64'(!ez));
      chk("busy_at_done", 64'(busy), 64'd0);
      @(negedge clk);
      chk("done_pulse_width", 64'(done), 64'd0);
      mhi = eh;
      mlo = el;
   endtask

   initial begin
      vec_t vecs[10];
      int cyc, seen;
      logic [1:0] o;
      logic [31:0] a, b, eh, el;
      logic ez;

      vecs[0] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[1] = '{2'b01, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[2] = '{2'b01, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
      vecs[3] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[4] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[6] = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      vecs[7] = '{2'b01, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
`ifdef MULDIV_UNSIGNED_EN
      vecs[5] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
      vecs[8] = '{2'b11, 32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0};
      vecs[9] = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
`else
      vecs[5] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
      vecs[8] = '{2'b11, 32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vecs[9] = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
`endif

      reset_in = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
      repeat (2) @(negedge clk);
      reset_in = 1'b0;
      @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_div_zero", 64'(div_zero), 64'd0);
      chk("reset_hi_lo_w", 64'(hi_lo_w), 64'd0);
      chk("reset_hi", 64'(hi_out), 64'd0);
      chk("reset_lo", 64'(lo_out), 64'd0);

      foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);

      // start while busy is dropped, not queued
      start = 1'b1; op = 2'b00; a_in = 32'd3; b_in = 32'd4;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      repeat (9) begin @(negedge clk); cyc++; end
      start = 1'b1; op = 2'b01; a_in = 32'd100; b_in = 32'd100;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      while (!done && cyc < 60) begin @(negedge clk); cyc++; end
      chk("busy_start_latency", 64'(cyc), 64'(WIDTH + 2));
      chk("busy_start_lo", 64'(lo_out), 64'd12);
      chk("busy_start_hi", 64'(hi_out), 64'd0);
      seen = 0;
      repeat (40) begin @(negedge clk); if (done) seen++; end
      chk("no_queued_start", 64'(seen), 64'd0);

      // reset mid-operation aborts without a strobe
      start = 1'b1; op = 2'b00; a_in = 32'h1234; b_in = 32'h5678;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      start = 1'b1; a_in = 32'd7; b_in = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("busy_mid_op", 64'(busy), 64'd1);
      reset_in = 1'b1;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hi", 64'(hi_out), 64'd0);
      chk("abort_lo", 64'(lo_out), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      @(negedge clk);
      reset_in = 1'b0;
      seen = 0;
      repeat (50) begin @(negedge clk); if (done || hi_lo_w) seen++; end
      chk("no_done_after_abort", 64'(seen), 64'd0);
      mhi = '0; mlo = '0;
      do_op(2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

      for (int n = 0; n < 40; n++) begin
         o = 2'($urandom_range(0, 3));
         a = rnd_val();
         b = rnd_val();
         model(o, a, b, mhi, mlo, eh, el, ez);
         do_op(o, a, b, eh, el, ez);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multicycle multiply/divide engine with its own sequencing FSM, serving the main control unit.
- The control unit pulses start with an operation and two operands (from the A/B registers).
- The block iterates one bit per cycle, then delivers HI/LO results with a single write strobe and a done pulse.
- It flags divide-by-zero so the control unit can branch to the exception path through the EXC mux and EPC.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
clk  in  1  system clock, rising edge.
reset_in  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
op  in  2  00 = MULT (signed), 01 = DIV (signed), 10 = MULTU, 11 = DIVU (the last two only with the optional feature).
a_in  in  WIDTH  multiplicand / dividend (rs).
b_in  in  WIDTH  multiplier / divisor (rt).
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle completion pulse.
div_zero  out  1  one-cycle pulse, concurrent with done, when a divide had a zero divisor.
hi_lo_w  out  1  one-cycle HI/LO register write strobe, concurrent with done.
hi_out  out  WIDTH  MULT: upper product; DIV: remainder.
lo_out  out  WIDTH  MULT: lower product; DIV: quotient.

Behaviour:
Reset (asynchronous):
- State = IDLE.
- busy, done, div_zero, hi_lo_w = 0.
- hi_out, lo_out, counter and internal accumulators = 0.
- Reset mid-operation aborts with no strobe.

FSM states: IDLE, LOAD, RUN, FIX, DONE.
- IDLE: start=1 latches op, a_in, b_in → LOAD. start=0 → stay.
- LOAD (busy=1):
  - Signed ops: operands converted to magnitudes; result sign recorded (MULT: sa^sb; DIV: quotient sa^sb, remainder sa).
  - Divide with b=0 → DONE directly, with div_zero to be asserted.
  - Otherwise counter=0 → RUN.
- RUN (busy=1), one iteration per cycle, WIDTH iterations, counter increments:
  - MULT: shift-add on a 2*WIDTH accumulator.
  - DIV: restoring shift-subtract; quotient bit = 1 when the trial remainder is ≥ 0.
  - counter == WIDTH-1 → FIX.
- FIX (busy=1):
  - Applies two's-complement sign correction to the 2*WIDTH product, or to quotient and remainder.
  - Loads hi_out/lo_out → DONE.
- DONE:
  - done=1 and hi_lo_w=1 (hi_lo_w=0 if div_zero).
  - busy=0, → IDLE.

Latency:
- start accepted at edge N → done high in the cycle after edge N+WIDTH+2 (34 cycles for WIDTH=32), for both MULT and DIV.
- Divide-by-zero: done after edge N+2.

Rules:
- start while busy or in DONE: ignored, not queued.
- Back-to-back: start may be asserted the cycle after done.
- Operands captured at acceptance; a_in/b_in changes during busy have no effect.
- DIV follows MIPS semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
- Signed overflow, -2^31 / -1: lo_out = 0x80000000, hi_out = 0; no flag.
- Divide-by-zero: hi_out/lo_out keep their previous values.
- MULT of -2^31 * -2^31: HI=0x40000000, LO=0x00000000.
- Outputs hold between operations.

Optional Feature:
MULDIV_UNSIGNED_EN
- Defined: op 10 (MULTU) and 11 (DIVU) skip sign conversion in LOAD and sign correction in FIX. Timing is identical to the signed ops.
- Undefined: op[1] is ignored and the ops behave as the signed ops selected by op[0]. No unsigned logic is synthesized.

Test Plan:
1. MULT a=0x00000007, b=0xFFFFFFFD (-3) → done 34 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB; hi_lo_w pulses once.
2. DIV a=0xFFFFFFF9 (-7), b=0x00000002 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1), div_zero=0.
3. DIV a=0x00000064, b=0 → done and div_zero after 2 cycles; hi_lo_w=0; HI/LO retain the previous result.
4. DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0x00000000.
5. MULT started; start re-asserted with new operands at cycle 10; reset_in pulsed at cycle 20 → second start ignored; at reset busy=0 and HI/LO=0; no done; a new MULT 5*6 then gives LO=30, HI=0.
6. With MULDIV_UNSIGNED_EN: MULTU 0xFFFFFFFF*0x00000002 → HI=0x00000001, LO=0xFFFFFFFE. Without it, op=10 gives HI=0xFFFFFFFF, LO=0xFFFFFFFE.
